// File: rtl/n64_ctrl_responder.sv
// N64 controller joybus responder: decodes console commands, sends button word.
// Optional N64_CTRL_STATUS_RESP_EN answers 0x00/0xFF with the status word.
module n64_ctrl_responder #(
  parameter int TURNAROUND = 8
) (
  input  logic        CLK_4M,
  input  logic        nRST,
  input  logic        CTRL_IN,
  input  logic [31:0] BTN_DATA,
  output logic        CTRL_OE,
  output logic        DATA_LATCH,
  output logic        BUSY,
  output logic        RESP_DONE
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD_RD,
    ST_STOP,
    ST_TURN,
    ST_TX,
    ST_TX_STOP
  } state_t;

  localparam logic [5:0] TURN_LAST = 6'(TURNAROUND - 1);
`ifdef N64_CTRL_STATUS_RESP_EN
  // 0x050002 bit-reversed so it leaves LSB-first as MSB-first
  localparam logic [31:0] STATUS_REV = 32'h004000A0;
`endif

  state_t      state, state_n;
  logic        s1, s2, prv;
  logic [5:0]  hi_cnt, hi_n;
  logic [5:0]  cnt, cnt_n;
  logic [5:0]  bit_cnt, bit_n;
  logic [5:0]  len, len_n;
  logic [7:0]  cmd, cmd_n;
  logic [31:0] sr, sr_n;
  logic        oe, oe_n;
  logic        busy, busy_n;
  logic        latch, latch_n;
  logic        done, done_n;
  logic        fall, rise, cnt_max;
  logic [5:0]  cnt_inc;

  assign fall    = prv & ~s2;
  assign rise    = ~prv & s2;
  assign cnt_inc = cnt + 6'd1;
  assign cnt_max = (cnt == 6'd31);

  // Two-flop synchronizer plus previous level for edge detection
  always_ff @(posedge CLK_4M or negedge nRST) begin
    if (!nRST) begin
      s1  <= 1'b1;
      s2  <= 1'b1;
      prv <= 1'b1;
    end else begin
      s1  <= CTRL_IN;
      s2  <= s1;
      prv <= s2;
    end
  end

  // State and datapath registers, outputs included
  always_ff @(posedge CLK_4M or negedge nRST) begin
    if (!nRST) begin
      state   <= ST_IDLE;
      hi_cnt  <= '0;
      cnt     <= '0;
      bit_cnt <= '0;
      len     <= '0;
      cmd     <= '0;
      sr      <= '0;
      oe      <= 1'b0;
      busy    <= 1'b0;
      latch   <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      hi_cnt  <= hi_n;
      cnt     <= cnt_n;
      bit_cnt <= bit_n;
      len     <= len_n;
      cmd     <= cmd_n;
      sr      <= sr_n;
      oe      <= oe_n;
      busy    <= busy_n;
      latch   <= latch_n;
      done    <= done_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n = state;
    hi_n    = hi_cnt;
    cnt_n   = cnt;
    bit_n   = bit_cnt;
    len_n   = len;
    cmd_n   = cmd;
    sr_n    = sr;
    oe_n    = oe;
    busy_n  = busy;
    latch_n = 1'b0;
    done_n  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!s2)
          hi_n = '0;
        else if (hi_cnt != 6'd63)
          hi_n = hi_cnt + 6'd1;
        if (fall && hi_cnt == 6'd63) begin
          state_n = ST_CMD_RD;
          hi_n    = '0;
          cnt_n   = 6'd1;
          bit_n   = '0;
          cmd_n   = '0;
        end
      end
      ST_CMD_RD: begin
        if (rise) begin
          cmd_n = {cmd[6:0], cnt < 6'd8};
          cnt_n = 6'd1;
          if (bit_cnt == 6'd7) begin
            state_n = ST_STOP;
            bit_n   = '0;
          end else begin
            bit_n = bit_cnt + 6'd1;
          end
        end else if (fall) begin
          cnt_n = 6'd1;
        end else if (cnt_max) begin
          state_n = ST_IDLE;
          hi_n    = '0;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      ST_STOP: begin
        if (rise) begin
          state_n = ST_IDLE;
          hi_n    = '0;
          cnt_n   = '0;
          bit_n   = '0;
          if (cmd == 8'h01) begin
            state_n = ST_TURN;
            sr_n    = BTN_DATA;
            len_n   = 6'd32;
            latch_n = 1'b1;
            busy_n  = 1'b1;
          end
`ifdef N64_CTRL_STATUS_RESP_EN
          else if (cmd == 8'h00 || cmd == 8'hFF) begin
            state_n = ST_TURN;
            sr_n    = STATUS_REV;
            len_n   = 6'd24;
            busy_n  = 1'b1;
          end
`endif
        end else if (fall) begin
          cnt_n = 6'd1;
        end else if (cnt_max) begin
          state_n = ST_IDLE;
          hi_n    = '0;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      ST_TURN: begin
        if (cnt == TURN_LAST) begin
          state_n = ST_TX;
          cnt_n   = '0;
          oe_n    = 1'b1;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      ST_TX: begin
        if (cnt == 6'd15) begin
          cnt_n = '0;
          sr_n  = sr >> 1;
          oe_n  = 1'b1;
          if (bit_cnt == len - 6'd1)
            state_n = ST_TX_STOP;
          else
            bit_n = bit_cnt + 6'd1;
        end else begin
          cnt_n = cnt_inc;
          oe_n  = cnt_inc < (sr[0] ? 6'd4 : 6'd12);
        end
      end
      ST_TX_STOP: begin
        if (cnt == 6'd7) begin
          state_n = ST_IDLE;
          oe_n    = 1'b0;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          hi_n    = '0;
          cnt_n   = '0;
          bit_n   = '0;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign CTRL_OE    = oe;
  assign DATA_LATCH = latch;
  assign BUSY       = busy;
  assign RESP_DONE  = done;

endmodule

// File: tb/tb_n64_ctrl_responder.sv
// Bench for n64_ctrl_responder: console frames, waveform model, reset cases.
// Status-response expectations follow N64_CTRL_STATUS_RESP_EN.
module tb_n64_ctrl_responder;

  localparam int T        = 8;
  localparam int SYNC_LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        line = 1'b1;
  logic [31:0] btn = '0;
  logic        ctrl_in;
  logic        oe, latch, busy, done;

  int vectors = 0;
  int errors  = 0;

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] data;
    int          nbits;
  } vec_t;

  vec_t tbl[8];

  assign ctrl_in = line & ~oe;

  always #5 clk = ~clk;

  n64_ctrl_responder #(.TURNAROUND(T)) dut (
    .CLK_4M    (clk),
    .nRST      (rst_n),
    .CTRL_IN   (ctrl_in),
    .BTN_DATA  (btn),
    .CTRL_OE   (oe),
    .DATA_LATCH(latch),
    .BUSY      (busy),
    .RESP_DONE (done)
  );

  function automatic int model_len(logic [7:0] c);
    if (c == 8'h01) return 32;
`ifdef N64_CTRL_STATUS_RESP_EN
    if (c == 8'h00 || c == 8'hFF) return 24;
`endif
    return 0;
  endfunction

  function automatic logic [31:0] model_seq(
    logic [7:0] c, logic [31:0] d);
    logic [23:0] st;
    logic [31:0] s;
    st = 24'h050002;
    s  = '0;
    if (c == 8'h01) return d;
    for (int i = 0; i < 24; i++)
      s[i] = st[23 - i];
    return s;
  endfunction

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(bit b);
    line = 1'b0;
    tick(b ? 4 : 12);
    line = 1'b1;
    tick(b ? 12 : 4);
  endtask

  task automatic send_cmd(logic [7:0] c);
    for (int i = 7; i >= 0; i--)
      send_bit(c[i]);
    line = 1'b0;
    tick(4);
    line = 1'b1;
  endtask

  task automatic check(string name,
    logic [3:0] act, logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t: oe/latch/busy/done=%b expected %b",
        name, $time, act, exp);
    end
  endtask

  task automatic check_window(string name, logic [31:0] seq,
    int nbits, bit latch_exp, int win);
    int start, endi, r, ph;
    logic e_oe, e_busy, e_latch, e_done, b;
    start = SYNC_LAT + T;
    endi  = start + 16 * nbits + 8;
    for (int m = 0; m < win; m++) begin
      @(negedge clk);
      e_oe = 0; e_busy = 0; e_latch = 0; e_done = 0;
      if (nbits > 0) begin
        r = m - start;
        if (r >= 0 && r < 16 * nbits) begin
          ph   = r % 16;
          b    = seq[r / 16];
          e_oe = ph < (b ? 4 : 12);
        end else if (r >= 16 * nbits && r < 16 * nbits + 8) begin
          e_oe = 1;
        end
        e_busy  = m >= SYNC_LAT && m < endi;
        e_done  = m == endi;
        e_latch = latch_exp && m == SYNC_LAT;
      end
      check(name, {oe, latch, busy, done},
        {e_oe, e_latch, e_busy, e_done});
      if (m >= SYNC_LAT) btn = $urandom;
    end
  endtask

  task automatic run_frame(string name,
    logic [7:0] c, logic [31:0] d, int nbits);
    int win;
    tick(70);
    btn = d;
    send_cmd(c);
    win = (nbits > 0) ? SYNC_LAT + T + 16 * nbits + 14 : 60;
    check_window(name, model_seq(c, d), nbits, c == 8'h01, win);
  endtask

  initial begin
    logic [7:0]  rc;
    logic [31:0] rd;

    tbl[0] = '{8'h01, 32'h0000_0001, 32};
    tbl[1] = '{8'h01, 32'hFFFF_FFFF, 32};
    tbl[2] = '{8'h01, 32'hA5A5_0F0F, 32};
    tbl[3] = '{8'h03, 32'h1234_5678, 0};
    tbl[4] = '{8'h80, 32'h0000_0000, 0};
    tbl[5] = '{8'h02, 32'hDEAD_BEEF, 0};
`ifdef N64_CTRL_STATUS_RESP_EN
    tbl[6] = '{8'hFF, 32'h0F0F_0F0F, 24};
    tbl[7] = '{8'h00, 32'h0000_0000, 24};
`else
    tbl[6] = '{8'hFF, 32'h0F0F_0F0F, 0};
    tbl[7] = '{8'h00, 32'h0000_0000, 0};
`endif

    tick(3);
    check("reset", {oe, latch, busy, done}, 4'b0000);
    rst_n = 1'b1;

    tick(20);
    send_cmd(8'h01);
    check_window("early_fall", '0, 0, 0, 40);
    tick(64);
    btn = 32'h0000_0001;
    send_cmd(8'h01);
    check_window("after_idle", 32'h0000_0001, 32, 1,
      SYNC_LAT + T + 16 * 32 + 14);

    for (int i = 0; i < 8; i++)
      run_frame($sformatf("tbl%0d", i),
        tbl[i].cmd, tbl[i].data, tbl[i].nbits);

    tick(70);
    send_bit(0);
    send_bit(0);
    send_bit(0);
    line = 1'b0;
    tick(40);
    line = 1'b1;
    check_window("stall_abort", '0, 0, 0, 60);

    tick(70);
    rd = $urandom & 32'hFFFF_FBFF;
    btn = rd;
    send_cmd(8'h01);
    check_window("pre_reset", rd, 32, 1,
      SYNC_LAT + T + 16 * 10 + 6);
    check("bit10_high", {oe, latch, busy, done}, 4'b1010);
    #1 rst_n = 1'b0;
    #1 check("rst_release", {oe, latch, busy, done}, 4'b0000);
    tick(3);
    rst_n = 1'b1;
    run_frame("post_reset", 8'h01, 32'h8000_4001, 32);

    for (int i = 0; i < 8; i++) begin
      rc = ($urandom_range(0, 1) == 1) ? 8'h01
                                       : 8'($urandom_range(0, 255));
      rd = $urandom;
      run_frame($sformatf("rnd%0d", i), rc, rd, model_len(rc));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
      vectors, errors);
    $finish;
  end

endmodule

// File: doc/n64_ctrl_responder.md
N64_CTRL_RESPONDER -- requirements
Module: n64_ctrl_responder

Interface
REQ-001 SHALL have parameter TURNAROUND, default 8, giving the clocks from console stop-bit rising edge to first response low drive (range 4..15).
REQ-002 SHALL have port CLK_4M, input, 1 bit: the single clock, 4 MHz (one joybus µs = 4 clocks).
REQ-003 SHALL have port nRST, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port CTRL_IN, input, 1 bit: joybus line level, asynchronous to CLK_4M.
REQ-005 SHALL have port BTN_DATA, input, 32 bits: response word; bit 0 is transmitted first (A, B, Z, St, Du, Dd, Dl, Dr, JR, 0, L, R, Cu, Cd, Cl, Cr, X[7:0], Y[7:0]).
REQ-006 SHALL have port CTRL_OE, output, 1 bit: 1 drives the open-drain joybus low, 0 releases it.
REQ-007 SHALL have port DATA_LATCH, output, 1 bit: one-clock pulse when BTN_DATA is captured.
REQ-008 SHALL have port BUSY, output, 1 bit: high from command acceptance through the end of the response stop bit.
REQ-009 SHALL have port RESP_DONE, output, 1 bit: one-clock pulse when the response stop bit completes.

Function
REQ-010 SHALL pass CTRL_IN through a 2-flop synchronizer; all edge detection uses the synchronized level, so input latency is 2 clocks.
REQ-011 SHALL use states ST_IDLE, ST_CMD_RD, ST_STOP, ST_TURN, ST_TX, ST_TX_STOP.
REQ-012 ST_IDLE: a 6-bit high-time counter saturates at 63; a falling edge moves to ST_CMD_RD only when the counter is saturated. Earlier falling edges are ignored.
REQ-013 ST_CMD_RD: measure each low-pulse width; a low of fewer than 8 clocks decodes as 1, a low of 8 or more as 0; bits shift in MSB first; after 8 bits go to ST_STOP.
REQ-014 In ST_CMD_RD or ST_STOP, any low or high phase lasting 32 clocks SHALL abort to ST_IDLE with no response.
REQ-015 ST_STOP: on the rising edge ending the next low pulse, decode the command byte.
- 0x01: capture BTN_DATA, pulse DATA_LATCH, set BUSY, length 32, go to ST_TURN.
- Any other byte (see REQ-025): go to ST_IDLE with no response.
REQ-016 ST_TURN: assert CTRL_OE exactly TURNAROUND clocks after the decode cycle, then enter ST_TX.
REQ-017 ST_TX: each bit is 16 clocks.
- Bit 0: CTRL_OE high 12 clocks, low 4 clocks.
- Bit 1: CTRL_OE high 4 clocks, low 12 clocks.
REQ-018 ST_TX_STOP: CTRL_OE high 8 clocks, then low; pulse RESP_DONE, clear BUSY, go to ST_IDLE with the high-time counter cleared.
REQ-019 The captured word SHALL be immune to BTN_DATA changes after DATA_LATCH.
REQ-020 CTRL_IN edges during ST_TURN, ST_TX and ST_TX_STOP SHALL be ignored; the response is never cut short.
REQ-021 The bit counter SHALL be 6 bits wide and SHALL terminate at length−1 without wrap.
REQ-022 All outputs SHALL be registered.

Reset
REQ-023 On nRST low, SHALL immediately set CTRL_OE, BUSY, DATA_LATCH and RESP_DONE to 0, set state to ST_IDLE, clear all counters and the shift register, and set the synchronizer to 1.
REQ-024 Reset asserted mid-response SHALL release the bus at once. After release, at least 64 high clocks are needed before a new command is accepted.

Configuration
REQ-025 Macro N64_CTRL_STATUS_RESP_EN:
- Defined: commands 0x00 and 0xFF are answered with the 24-bit status 0x050002, sent MSB first, with identical timing; DATA_LATCH is not pulsed.
- Undefined: 0x00 and 0xFF are treated as unknown commands (no response).

Verification
REQ-026 After 64 idle clocks, console sends 0x01 plus stop bit, BTN_DATA=0x00000001 -> DATA_LATCH pulse; CTRL_OE rises 8 clocks after the stop rising edge; first bit is a 4-clock low (1); the next 31 bits are 12-clock lows; then an 8-clock stop; RESP_DONE pulses.
REQ-027 Command 0x03 -> no CTRL_OE assertion, BUSY stays 0.
REQ-028 With the macro defined, command 0xFF -> 24 bits 0x050002 then stop; with the macro undefined -> no response.
REQ-029 A falling edge after only 20 idle clocks -> ignored; a valid 0x01 frame that follows after 64 high clocks -> answered.
REQ-030 nRST asserted during bit 10 of the response -> CTRL_OE=0 in the same cycle; the next valid 0x01 frame is answered normally.
REQ-031 Console stalls low for 40 clocks after 3 command bits -> abort, no response, BUSY=0.
